// File: rtl/cim_pkg.sv
// Shared types for the CIM tile path: Winograd output tiles and the
// {tile, address} packets that move from the PE array into CIM lanes.
package cim_pkg;

    localparam int TILE_N = 6;
    localparam int TILE_W = 12;
    localparam int ADDR_W = 8;

    // 6x6 tile of signed 12-bit elements, element [0][0] in the MSBs
    typedef logic signed [0:TILE_N-1][0:TILE_N-1][TILE_W-1:0] tile_t;

    typedef struct packed {
        tile_t             tile;
        logic [ADDR_W-1:0] addr;
    } tile_pkt_t;

endpackage

// File: rtl/tile_fifo.sv
// Circular tile buffer: one push per cycle, zero to two pops per cycle,
// with the head and the entry behind it visible for dual issue.
module tile_fifo
    import cim_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  tile_pkt_t        push_pkt,
    input  logic [1:0]       pop_n,
    output tile_pkt_t        head,
    output tile_pkt_t        second,
    output logic [CNT_W-1:0] count
);

    tile_pkt_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage write; payload is never reset, only the pointers are
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_pkt;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr <= rd_ptr + PTR_W'(pop_n);
            count  <= count + CNT_W'(push) - CNT_W'(pop_n);
        end
    end

    assign head   = mem[rd_ptr];
    assign second = mem[rd_ptr + PTR_W'(1)];

endmodule

// File: rtl/pe_tile_dispatch.sv
// Dispatches buffered PE tiles onto two CIM lanes in strict order, holding
// back any tile whose address was written within the last HAZARD_WIN
// dispatch cycles so the output memory never sees overlapping writes.
module pe_tile_dispatch
    import cim_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HAZARD_WIN = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  tile_t             in_tile,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              in_valid,
    output logic              in_ready,
    output tile_t             PE_tile_o_1,
    output tile_t             PE_tile_o_2,
    output logic [ADDR_W-1:0] PE_addr_o_1,
    output logic [ADDR_W-1:0] PE_addr_o_2,
    output logic              PE_valid_o_1,
    output logic              PE_valid_o_2,
    output logic [15:0]       dispatch_count,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  fifo_count;
    tile_pkt_t         head_pkt;
    tile_pkt_t         second_pkt;
    tile_pkt_t         push_pkt;
    logic              push;
    logic [1:0]        pop_n;

    logic              h0_hit;
    logic              h1_hit;
    logic              disp0_vld_p0;
    logic              disp1_vld_p0;

    // Hazard history: stage 0 holds the addresses issued at the last edge
    logic [ADDR_W-1:0] hist_addr_p [HAZARD_WIN][2];
    logic              hist_vld_p  [HAZARD_WIN][2];

    // Readiness uses the registered count only; a pop in this cycle does
    // not free a slot until the next one
    assign in_ready = !reset && (fifo_count < CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign push_pkt = '{tile: in_tile, addr: in_addr};

    tile_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_pkt (push_pkt),
        .pop_n    (pop_n),
        .head     (head_pkt),
        .second   (second_pkt),
        .count    (fifo_count)
    );

    // Eligibility of the two oldest entries against the hazard window
    always_comb begin
        h0_hit = 1'b0;
        h1_hit = 1'b0;
        for (int s = 0; s < HAZARD_WIN; s++) begin
            for (int k = 0; k < 2; k++) begin
                if (hist_vld_p[s][k] && (hist_addr_p[s][k] == head_pkt.addr)) begin
                    h0_hit = 1'b1;
                end
                if (hist_vld_p[s][k] && (hist_addr_p[s][k] == second_pkt.addr)) begin
                    h1_hit = 1'b1;
                end
            end
        end
        disp0_vld_p0 = (fifo_count != '0) && !h0_hit;
        disp1_vld_p0 = disp0_vld_p0 && (fifo_count >= CNT_W'(2)) &&
                       (second_pkt.addr != head_pkt.addr) && !h1_hit;
        pop_n        = disp1_vld_p0 ? 2'd2 : (disp0_vld_p0 ? 2'd1 : 2'd0);
    end

    // Lane output registers; data holds on idle cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            PE_valid_o_1 <= 1'b0;
            PE_valid_o_2 <= 1'b0;
            PE_tile_o_1  <= '0;
            PE_tile_o_2  <= '0;
            PE_addr_o_1  <= '0;
            PE_addr_o_2  <= '0;
        end else begin
            PE_valid_o_1 <= disp0_vld_p0;
            PE_valid_o_2 <= disp1_vld_p0;
            if (disp0_vld_p0) begin
                PE_tile_o_1 <= head_pkt.tile;
                PE_addr_o_1 <= head_pkt.addr;
            end
            if (disp1_vld_p0) begin
                PE_tile_o_2 <= second_pkt.tile;
                PE_addr_o_2 <= second_pkt.addr;
            end
        end
    end

    // History valid bits shift one stage per edge and clear on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < HAZARD_WIN; s++) begin
                hist_vld_p[s][0] <= 1'b0;
                hist_vld_p[s][1] <= 1'b0;
            end
        end else begin
            hist_vld_p[0][0] <= disp0_vld_p0;
            hist_vld_p[0][1] <= disp1_vld_p0;
            for (int s = 1; s < HAZARD_WIN; s++) begin
                hist_vld_p[s][0] <= hist_vld_p[s-1][0];
                hist_vld_p[s][1] <= hist_vld_p[s-1][1];
            end
        end
    end

    // History addresses shift alongside their valid bits
    always_ff @(posedge clk) begin
        hist_addr_p[0][0] <= head_pkt.addr;
        hist_addr_p[0][1] <= second_pkt.addr;
        for (int s = 1; s < HAZARD_WIN; s++) begin
            hist_addr_p[s][0] <= hist_addr_p[s-1][0];
            hist_addr_p[s][1] <= hist_addr_p[s-1][1];
        end
    end

    // Running dispatch total, wraps modulo 2^16
    always_ff @(posedge clk) begin
        if (reset) begin
            dispatch_count <= '0;
        end else begin
            dispatch_count <= dispatch_count + 16'(pop_n);
        end
    end

    assign busy = (fifo_count != '0) || PE_valid_o_1 || PE_valid_o_2;

endmodule

// File: tb/tb_pe_tile_dispatch.sv
// Bench for pe_tile_dispatch: directed cycle table, randomized traffic
// against a queue-based reference model, and a counter wrap sequence.
module tb_pe_tile_dispatch;
    import cim_pkg::*;

    localparam int DEPTH = 4;
    localparam int HW    = 2;

    logic              clk = 1'b0;
    logic              reset;
    tile_t             in_tile;
    logic [ADDR_W-1:0] in_addr;
    logic              in_valid;
    logic              in_ready;
    tile_t             PE_tile_o_1;
    tile_t             PE_tile_o_2;
    logic [ADDR_W-1:0] PE_addr_o_1;
    logic [ADDR_W-1:0] PE_addr_o_2;
    logic              PE_valid_o_1;
    logic              PE_valid_o_2;
    logic [15:0]       dispatch_count;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_tile_dispatch #(
        .DEPTH      (DEPTH),
        .HAZARD_WIN (HW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_tile        (in_tile),
        .in_addr        (in_addr),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .PE_tile_o_1    (PE_tile_o_1),
        .PE_tile_o_2    (PE_tile_o_2),
        .PE_addr_o_1    (PE_addr_o_1),
        .PE_addr_o_2    (PE_addr_o_2),
        .PE_valid_o_1   (PE_valid_o_1),
        .PE_valid_o_2   (PE_valid_o_2),
        .dispatch_count (dispatch_count),
        .busy           (busy)
    );

    // Reference model: a queue of waiting tiles and, per address, the
    // edge number of its most recent dispatch.
    tile_pkt_t   mq[$];
    longint      last_edge [256];
    longint      edge_n = 0;
    bit          m_v1, m_v2;
    tile_t       m_t1, m_t2;
    logic [7:0]  m_a1, m_a2;
    logic [15:0] m_dc;

    typedef struct {
        bit          rst;
        bit          vld;
        logic [7:0]  addr;
        bit          ev1;
        logic [7:0]  ea1;
        bit          ev2;
        logic [7:0]  ea2;
        bit          erdy;
        logic [15:0] edc;
        bit          cb;
        bit          eb;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(bit rst, bit vld, logic [7:0] addr,
                                bit ev1, logic [7:0] ea1, bit ev2, logic [7:0] ea2,
                                bit erdy, logic [15:0] edc, bit cb, bit eb);
        vec_t v;
        v.rst = rst;  v.vld = vld;  v.addr = addr;
        v.ev1 = ev1;  v.ea1 = ea1;  v.ev2 = ev2;  v.ea2 = ea2;
        v.erdy = erdy; v.edc = edc; v.cb = cb;    v.eb = eb;
        return v;
    endfunction

    function automatic tile_t rand_tile();
        tile_t t;
        for (int r = 0; r < TILE_N; r++) begin
            for (int c = 0; c < TILE_N; c++) begin
                t[r][c] = TILE_W'($urandom);
            end
        end
        return t;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs seen at that edge
    task automatic model_edge();
        bit e0;
        bit e1;
        int sz;
        bit do_push;
        edge_n++;
        if (reset) begin
            mq.delete();
            m_v1 = 1'b0; m_v2 = 1'b0;
            m_t1 = '0;   m_t2 = '0;
            m_a1 = '0;   m_a2 = '0;
            m_dc = '0;
            for (int a = 0; a < 256; a++) last_edge[a] = -1000;
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            sz = mq.size();
            do_push = in_valid && (sz < DEPTH);
            if (sz >= 1 && (edge_n - last_edge[mq[0].addr]) > HW) e0 = 1'b1;
            if (e0 && sz >= 2 && mq[1].addr != mq[0].addr &&
                (edge_n - last_edge[mq[1].addr]) > HW) e1 = 1'b1;
            m_v1 = e0;
            m_v2 = e1;
            if (e0) begin
                m_t1 = mq[0].tile;
                m_a1 = mq[0].addr;
                last_edge[mq[0].addr] = edge_n;
            end
            if (e1) begin
                m_t2 = mq[1].tile;
                m_a2 = mq[1].addr;
                last_edge[mq[1].addr] = edge_n;
            end
            if (e0) void'(mq.pop_front());
            if (e1) void'(mq.pop_front());
            m_dc = m_dc + 16'(e0) + 16'(e1);
            if (do_push) mq.push_back('{tile: in_tile, addr: in_addr});
        end
    endtask

    task automatic compare_model();
        chk("model_v1",   PE_valid_o_1, m_v1);
        chk("model_v2",   PE_valid_o_2, m_v2);
        chk("model_a1",   PE_addr_o_1, m_a1);
        chk("model_a2",   PE_addr_o_2, m_a2);
        chk("model_t1",   PE_tile_o_1, m_t1);
        chk("model_t2",   PE_tile_o_2, m_t2);
        chk("model_dc",   dispatch_count, m_dc);
        chk("model_rdy",  in_ready, !reset && (mq.size() < DEPTH));
        chk("model_busy", busy, (mq.size() != 0) || m_v1 || m_v2);
        chk("lane2_without_lane1", PE_valid_o_2 && !PE_valid_o_1, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_tile  = '0;

        // Reset state
        step();
        step();
        chk("rst_v1",   PE_valid_o_1, 1'b0);
        chk("rst_v2",   PE_valid_o_2, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dc",   dispatch_count, 16'h0000);
        chk("rst_rdy",  in_ready, 1'b0);

        // Directed cycle table: each row is driven for one edge and the
        // lanes are checked just after it. A leading tile at the same
        // address as the first of a group occupies the hazard window so
        // the group queues up behind it.
        //          rst vld addr  ev1 ea1   ev2 ea2   rdy dc   cb eb
        // back-to-back 0x10..0x13
        tv.push_back(mk(0, 1, 8'h10, 0, 8'h00, 0, 8'h00, 1, 16'd0, 0, 0));
        tv.push_back(mk(0, 1, 8'h10, 1, 8'h10, 0, 8'h00, 1, 16'd1, 0, 0));
        tv.push_back(mk(0, 1, 8'h11, 0, 8'h00, 0, 8'h00, 1, 16'd1, 0, 0));
        tv.push_back(mk(0, 1, 8'h12, 0, 8'h00, 0, 8'h00, 1, 16'd1, 0, 0));
        tv.push_back(mk(0, 1, 8'h13, 1, 8'h10, 1, 8'h11, 1, 16'd3, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 1, 8'h12, 1, 8'h13, 1, 16'd5, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd5, 1, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd5, 0, 0));
        // same address twice: second goes exactly 3 edges after the first
        tv.push_back(mk(0, 1, 8'h20, 0, 8'h00, 0, 8'h00, 1, 16'd5, 0, 0));
        tv.push_back(mk(0, 1, 8'h20, 1, 8'h20, 0, 8'h00, 1, 16'd6, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd6, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd6, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 1, 8'h20, 0, 8'h00, 1, 16'd7, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd7, 0, 0));
        // 0x30, 0x31, 0x30: dual issue, then the repeat stalls two cycles
        tv.push_back(mk(0, 1, 8'h30, 0, 8'h00, 0, 8'h00, 1, 16'd7, 0, 0));
        tv.push_back(mk(0, 1, 8'h30, 1, 8'h30, 0, 8'h00, 1, 16'd8, 0, 0));
        tv.push_back(mk(0, 1, 8'h31, 0, 8'h00, 0, 8'h00, 1, 16'd8, 0, 0));
        tv.push_back(mk(0, 1, 8'h30, 0, 8'h00, 0, 8'h00, 1, 16'd8, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 1, 8'h30, 1, 8'h31, 1, 16'd10, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd10, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd10, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 1, 8'h30, 0, 8'h00, 1, 16'd11, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd11, 0, 0));
        // fill to DEPTH behind a stalled head, then drain in order
        tv.push_back(mk(0, 1, 8'h40, 0, 8'h00, 0, 8'h00, 1, 16'd11, 0, 0));
        tv.push_back(mk(0, 1, 8'h40, 1, 8'h40, 0, 8'h00, 1, 16'd12, 0, 0));
        tv.push_back(mk(0, 1, 8'h40, 0, 8'h00, 0, 8'h00, 1, 16'd12, 0, 0));
        tv.push_back(mk(0, 1, 8'h41, 0, 8'h00, 0, 8'h00, 1, 16'd12, 0, 0));
        tv.push_back(mk(0, 1, 8'h42, 1, 8'h40, 0, 8'h00, 1, 16'd13, 0, 0));
        tv.push_back(mk(0, 1, 8'h43, 0, 8'h00, 0, 8'h00, 0, 16'd13, 0, 0));
        tv.push_back(mk(0, 1, 8'h44, 0, 8'h00, 0, 8'h00, 0, 16'd13, 1, 1));
        tv.push_back(mk(0, 1, 8'h44, 1, 8'h40, 1, 8'h41, 1, 16'd15, 0, 0));
        tv.push_back(mk(0, 1, 8'h44, 1, 8'h42, 1, 8'h43, 1, 16'd17, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 1, 8'h44, 0, 8'h00, 1, 16'd18, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd18, 0, 0));
        // reset with three tiles buffered, then a fresh tile
        tv.push_back(mk(0, 1, 8'h50, 0, 8'h00, 0, 8'h00, 1, 16'd18, 0, 0));
        tv.push_back(mk(0, 1, 8'h50, 1, 8'h50, 0, 8'h00, 1, 16'd19, 0, 0));
        tv.push_back(mk(0, 1, 8'h51, 0, 8'h00, 0, 8'h00, 1, 16'd19, 0, 0));
        tv.push_back(mk(0, 1, 8'h52, 0, 8'h00, 0, 8'h00, 1, 16'd19, 1, 1));
        tv.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 16'd0, 1, 0));
        tv.push_back(mk(0, 1, 8'h53, 0, 8'h00, 0, 8'h00, 1, 16'd0, 1, 1));
        tv.push_back(mk(0, 0, 8'h00, 1, 8'h53, 0, 8'h00, 1, 16'd1, 0, 0));
        tv.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 16'd1, 1, 0));

        foreach (tv[i]) begin
            reset    = tv[i].rst;
            in_valid = tv[i].vld;
            in_addr  = tv[i].addr;
            in_tile  = rand_tile();
            step();
            chk($sformatf("row%0d_v1", i), PE_valid_o_1, tv[i].ev1);
            chk($sformatf("row%0d_v2", i), PE_valid_o_2, tv[i].ev2);
            if (tv[i].ev1) chk($sformatf("row%0d_a1", i), PE_addr_o_1, tv[i].ea1);
            if (tv[i].ev2) chk($sformatf("row%0d_a2", i), PE_addr_o_2, tv[i].ea2);
            chk($sformatf("row%0d_rdy", i), in_ready, tv[i].erdy);
            chk($sformatf("row%0d_dc", i), dispatch_count, tv[i].edc);
            if (tv[i].cb) chk($sformatf("row%0d_busy", i), busy, tv[i].eb);
        end

        // Randomized traffic over a small address set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            reset    = ($urandom_range(0, 299) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            in_addr  = 8'($urandom_range(0, 7));
            in_tile  = rand_tile();
            step();
        end

        // Counter wrap: 65535 single dispatches, then one dual dispatch
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int n = 0; n < 65535; n++) begin
            in_valid = 1'b1;
            in_addr  = 8'(n);
            in_tile  = rand_tile();
            step();
        end
        in_addr = 8'hFE;
        in_tile = rand_tile();
        step();
        chk("wrap_pre_dc", dispatch_count, 16'hFFFF);
        in_addr = 8'h55;
        in_tile = rand_tile();
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("wrap_v1", PE_valid_o_1, 1'b1);
        chk("wrap_v2", PE_valid_o_2, 1'b1);
        chk("wrap_a1", PE_addr_o_1, 8'hFE);
        chk("wrap_a2", PE_addr_o_2, 8'h55);
        chk("wrap_dc", dispatch_count, 16'h0001);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
